// File: rtl/tof_capture.sv
// tof_capture: multi-channel sonar time-of-flight capture with register port.
// Define TOF_CAPTURE_IRQ_EN to build the completion interrupt (TW <= 16).
module tof_capture #(
  parameter int NCH = 4,
  parameter int TW  = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           start_i,
  input  logic           ce_pcm_i,
  input  logic [NCH-1:0] cmp_i,
  output logic           mclear_o,
  input  logic           wb_valid_i,
  input  logic [3:0]     wbs_adr_i,
  input  logic [15:0]    wbs_dat_i,
  input  logic           wbs_strb_i,
  output logic           wbs_ack_o,
  output logic [15:0]    wbs_dat_o,
  output logic           irq_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_BLANK  = 3'd2,
    S_LISTEN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  blank;
  logic [TW-1:0]  window;
  logic [TW-1:0]  tof [NCH];
  logic [NCH-1:0] captured;
  logic           enable;
  logic           irq_en;
  logic           done_flag;

  logic           wr;
  logic           wr_ctrl;
  logic [TW-1:0]  tick;
  logic [NCH-1:0] hits;
  logic           all_cap;
  logic [15:0]    status;
  logic [15:0]    rdata;

  function automatic logic [15:0] widen(input logic [TW-1:0] v);
    logic [15:0] r;
    r = '0;
    r[TW-1:0] = v;
    return r;
  endfunction

  function automatic logic [7:0] widen8(input logic [NCH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NCH-1:0] = v;
    return r;
  endfunction

  assign wr      = wb_valid_i & wbs_strb_i;
  assign wr_ctrl = wr && (wbs_adr_i == 4'd0);

  // saturating timer advance; never wraps past all-ones
  assign tick = (ce_pcm_i && (timer != '1)) ? timer + 1'b1 : timer;

  // first edge of each channel, only while listening
  assign hits    = (state == S_LISTEN) ? (cmp_i & ~captured) : '0;
  assign all_cap = &(captured | hits);

  assign status = {widen8(captured), 4'd0, done_flag, state};

  // register read multiplexer
  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      4'd0:  rdata = {14'd0, irq_en, enable};
      4'd1:  rdata = status;
      4'd2:  rdata = widen(blank);
      4'd3:  rdata = widen(window);
      4'd12: rdata = widen(timer);
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (wbs_adr_i == 4'(4 + k)) rdata = widen(tof[k]);
        end
      end
    endcase
  end

  // bus response: ack one cycle after each access, data holds pre-write value
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_valid_i;
      if (wb_valid_i) wbs_dat_o <= rdata;
    end
  end

`ifdef TOF_CAPTURE_IRQ_EN
  // interrupt enable bit and registered interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wbs_dat_i[1];
      irq_o <= done_flag & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // configuration registers and measurement sequencer
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= S_IDLE;
      timer     <= '0;
      enable    <= 1'b0;
      blank     <= '0;
      window    <= '1;
      captured  <= '0;
      done_flag <= 1'b0;
      mclear_o  <= 1'b0;
      for (int k = 0; k < NCH; k++) tof[k] <= '1;
    end else begin
      mclear_o <= 1'b0;
      if (wr_ctrl) enable <= wbs_dat_i[0];
      if (wr && (wbs_adr_i == 4'd2)) blank <= wbs_dat_i[TW-1:0];
      if (wr && (wbs_adr_i == 4'd3)) window <= wbs_dat_i[TW-1:0];
      if (wr && (wbs_adr_i == 4'd1)) done_flag <= 1'b0;

      if (wr_ctrl && !wbs_dat_i[0]) begin
        state <= S_IDLE;
      end else if (start_i && enable && (state != S_CLEAR)) begin
        state     <= S_CLEAR;
        mclear_o  <= 1'b1;
        timer     <= '0;
        captured  <= '0;
        done_flag <= 1'b0;
        for (int k = 0; k < NCH; k++) tof[k] <= '1;
      end else begin
        case (state)
          S_CLEAR: state <= S_BLANK;
          S_BLANK: begin
            timer <= tick;
            if (tick >= blank) state <= S_LISTEN;
          end
          S_LISTEN: begin
            timer    <= tick;
            captured <= captured | hits;
            for (int k = 0; k < NCH; k++) begin
              if (hits[k]) tof[k] <= timer;
            end
            if (all_cap || (timer >= window)) begin
              state     <= S_DONE;
              done_flag <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tof_capture.sv
// tb_tof_capture: scoreboard bench for tof_capture.
// Register reads queue expectations; the ack monitor pops and compares.
module tb_tof_capture;
  localparam int NCH = 4;
  localparam int TW  = 16;
`ifdef TOF_CAPTURE_IRQ_EN
  localparam logic [15:0] CTRL_RB = 16'd3;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [15:0] CTRL_RB = 16'd1;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           ce    = 1'b0;
  logic [NCH-1:0] cmp   = '0;
  logic           valid = 1'b0;
  logic           strb  = 1'b0;
  logic [3:0]     adr   = '0;
  logic [15:0]    wdat  = '0;
  logic           mclear;
  logic           ack;
  logic [15:0]    rdat;
  logic           irq;

  int errors  = 0;
  int checks  = 0;
  int mclears = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  tof_capture #(.NCH(NCH), .TW(TW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .start_i   (start),
    .ce_pcm_i  (ce),
    .cmp_i     (cmp),
    .mclear_o  (mclear),
    .wb_valid_i(valid),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_strb_i(strb),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (mclear) mclears++;
    if (ack) begin
      check("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.tag, 32'(rdat), 32'(e.exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp,
                    input string tag);
    adr   = a;
    strb  = 1'b0;
    valid = 1'b1;
    push(tag, exp);
    step();
    valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d,
                    input logic [15:0] pre, input string tag);
    adr   = a;
    wdat  = d;
    strb  = 1'b1;
    valid = 1'b1;
    push(tag, pre);
    step();
    valid = 1'b0;
    strb  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      ce = 1'b1;
      step();
      ce = 1'b0;
      step();
    end
  endtask

  task automatic ping();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check("rst_out", 32'({mclear, ack, irq, rdat}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    rd(4'd0,  16'h0000, "rst_ctrl");
    rd(4'd1,  16'h0000, "rst_status");
    rd(4'd2,  16'h0000, "rst_blank");
    rd(4'd3,  16'hFFFF, "rst_window");
    rd(4'd4,  16'hFFFF, "rst_tof0");
    rd(4'd7,  16'hFFFF, "rst_tof3");
    rd(4'd12, 16'h0000, "rst_timer");
    rd(4'd13, 16'h0000, "unmapped");

    wr(4'd0, 16'd3,   16'h0000, "wr_ctrl_pre");
    rd(4'd0, CTRL_RB, "ctrl_rb");
    wr(4'd2, 16'd10,  16'h0000, "wr_blank_pre");
    wr(4'd3, 16'd500, 16'hFFFF, "wr_window_pre");
    rd(4'd2, 16'd10,  "blank_rb");
    rd(4'd3, 16'd500, "window_rb");

    // single echo on channel 2, window expiry
    ping();
    rd(4'd1, 16'h0002, "s1_blank_status");
    ticks(137);
    rd(4'd12, 16'd137, "s1_timer137");
    rd(4'd1, 16'h0003, "s1_listen_status");
    cmp[2] = 1'b1;
    step();
    cmp[2] = 1'b0;
    step();
    cmp[2] = 1'b1;
    step();
    ticks(363);
    rd(4'd1,  16'h040C, "s1_status");
    rd(4'd6,  16'd137,  "s1_tof2");
    rd(4'd4,  16'hFFFF, "s1_tof0");
    rd(4'd5,  16'hFFFF, "s1_tof1");
    rd(4'd7,  16'hFFFF, "s1_tof3");
    rd(4'd12, 16'd500,  "s1_timer");
    check("s1_mclear", 32'(mclears), 32'd1);

    // all channels capture, early done
    cmp = '0;
    wr(4'd2, 16'd5, 16'd10, "s2_blank_pre");
    ping();
    rd(4'd1, 16'h0002, "s2_done_cleared");
    ticks(40);
    cmp[0] = 1'b1;
    ticks(1);
    cmp[1] = 1'b1;
    ticks(1);
    cmp[2] = 1'b1;
    ticks(1);
    cmp[3] = 1'b1;
    ce = 1'b1;
    step();
    ce = 1'b0;
    rd(4'd1,  16'h0F0C, "s2_done_next");
    rd(4'd12, 16'd44,   "s2_timer");
    ticks(5);
    rd(4'd12, 16'd44,   "s2_timer_frozen");
    rd(4'd4,  16'd40,   "s2_tof0");
    rd(4'd7,  16'd43,   "s2_tof3");

    // compare already high before listening
    cmp = 4'b0001;
    wr(4'd2, 16'd20, 16'd5, "s3_blank_pre");
    ping();
    ticks(20);
    rd(4'd4, 16'd20, "s3_tof0");

    // restart mid-listen
    ticks(10);
    cmp[1] = 1'b1;
    ticks(1);
    ticks(19);
    rd(4'd5, 16'd30, "s4_tof1_first");
    start = 1'b1;
    cmp   = '0;
    step();
    start = 1'b0;
    rd(4'd12, 16'h0000, "s4_timer_restart");
    rd(4'd4,  16'hFFFF, "s4_tof0_cleared");
    rd(4'd5,  16'hFFFF, "s4_tof1_cleared");
    rd(4'd1,  16'h0002, "s4_status");
    check("s4_mclear", 32'(mclears), 32'd4);

    // disable mid-listen keeps results
    ticks(20);
    cmp[3] = 1'b1;
    step();
    wr(4'd0, 16'd0, CTRL_RB, "dis_ctrl_pre");
    rd(4'd1, 16'h0800, "dis_status");
    rd(4'd7, 16'd20,   "dis_tof_kept");
    ping();
    check("dis_no_mclear", 32'(mclears), 32'd4);
    rd(4'd1, 16'h0800, "dis_start_ignored");

    // blank beyond window, start held through clear
    cmp = '0;
    wr(4'd0, 16'd1,  16'd0,   "en_pre");
    wr(4'd2, 16'd30, 16'd20,  "s5_blank_pre");
    wr(4'd3, 16'd10, 16'd500, "s5_window_pre");
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    check("clear_ignores_start", 32'(mclears), 32'd5);
    ticks(30);
    rd(4'd1,  16'h000C, "short_window");
    rd(4'd12, 16'd30,   "short_timer");
    wr(4'd1, 16'd0, 16'h000C, "st_wr_pre");
    rd(4'd1, 16'h0004, "done_cleared_by_write");

    // interrupt set and clear
    wr(4'd0, 16'd3, 16'd1,  "irq_ctrl_pre");
    wr(4'd2, 16'd0, 16'd30, "irq_blank_pre");
    wr(4'd3, 16'd3, 16'd10, "irq_window_pre");
    ping();
    ticks(3);
    step();
    step();
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(4'd1, 16'd0, 16'h000C, "irq_st_pre");
    step();
    check("irq_clear", 32'(irq), 32'd0);

    // asynchronous reset while listening
    wr(4'd3, 16'd100, 16'd3, "ar_window_pre");
    ping();
    ticks(5);
    #3 rst_n = 1'b0;
    #1 check("async_rst_out", 32'({mclear, ack, irq, rdat}), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rd(4'd1, 16'h0000, "ar_idle");
    rd(4'd0, 16'h0000, "ar_ctrl");
    rd(4'd3, 16'hFFFF, "ar_window");
    check("ar_mclear", 32'(mclears), 32'd7);

    // long run, timer saturation
    wr(4'd0, 16'd1, 16'd0, "sat_en_pre");
    ping();
    ce = 1'b1;
    repeat (70000) step();
    ce = 1'b0;
    rd(4'd12, 16'hFFFF, "sat_timer");
    rd(4'd1,  16'h000C, "sat_done");
    check("sat_mclear", 32'(mclears), 32'd8);

    repeat (3) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tof_capture.md
TOF_CAPTURE -- requirements
Module: tof_capture

Interface
REQ-001 SHALL have parameter NCH, default 4, number of sonar channels observed (1..8).
REQ-002 SHALL have parameter TW, default 16, timer and time-of-flight width.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock.
REQ-004 SHALL have port wb_rst_i  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle ping-start strobe.
REQ-006 SHALL have port ce_pcm_i  input  1  PCM-rate tick, the time base.
REQ-007 SHALL have port cmp_i  input  NCH  latched compare outputs of the sonar channels.
REQ-008 SHALL have port mclear_o  output  1  master-clear pulse to the sonar channels.
REQ-009 SHALL have ports wb_valid_i in 1, wbs_adr_i in 4, wbs_dat_i in 16, wbs_strb_i in 1 (write), wbs_ack_o out 1, wbs_dat_o out 16.
REQ-010 SHALL have port irq_o  output  1  measurement-complete interrupt.

Function
REQ-011 Register map SHALL be: 0 CONTROL (bit0 enable, bit1 irq_en), 1 STATUS, 2 BLANK, 3 WINDOW, 4+k TOF[k] (read-only), 12 TIMER (read-only); unmapped addresses read 0.
REQ-012 For each cycle with wb_valid_i high, wbs_ack_o SHALL pulse the next cycle, and wbs_dat_o SHALL hold registered read data.
REQ-013 Writes with wbs_strb_i high SHALL update the addressed register on that same edge; the read data SHALL be the pre-write value.
REQ-014 FSM states SHALL be IDLE, CLEAR, BLANK, LISTEN, DONE.
REQ-015 FSM transitions:
- IDLE/DONE to CLEAR on start_i with CONTROL.enable=1.
- CLEAR to BLANK after exactly one cycle.
- BLANK to LISTEN when timer >= BLANK.
- LISTEN to DONE when all NCH channels have captured, or when timer >= WINDOW.
REQ-016 In CLEAR, mclear_o SHALL be 1 for exactly one cycle; the timer SHALL be cleared to 0; all TOF[k] SHALL be set to all-ones; the captured mask SHALL be cleared.
REQ-017 In BLANK and LISTEN, the timer SHALL increment on each ce_pcm_i; it SHALL saturate at all-ones, never wrap.
REQ-018 In LISTEN, on a cycle with cmp_i[k]=1 and channel k not yet captured, TOF[k] SHALL take the current timer value and captured[k] SHALL set; later cmp_i[k] activity SHALL be ignored.
REQ-019 cmp_i SHALL be ignored in IDLE, CLEAR, BLANK and DONE.
REQ-020 When capture and timer >= WINDOW occur in the same cycle, the capture SHALL be recorded before entering DONE.
REQ-021 start_i in BLANK or LISTEN SHALL restart the measurement (go to CLEAR); start_i in CLEAR SHALL be ignored.
REQ-022 Writing enable=0 SHALL force IDLE next cycle; TOF values SHALL be retained.
REQ-023 STATUS SHALL read: [2:0] state code (IDLE=0..DONE=4), [3] done_flag, [15:8] captured mask (zero-extended).
REQ-024 done_flag SHALL set on entry to DONE and clear on any STATUS write or on entry to CLEAR.
REQ-025 If BLANK >= WINDOW, LISTEN SHALL last one cycle, then enter DONE with no captures.

Reset
REQ-026 On wb_rst_i low, asynchronously: state=IDLE, timer=0, CONTROL=0, BLANK=0, WINDOW=all-ones, TOF[k]=all-ones, captured=0, done_flag=0.
REQ-027 Output reset values SHALL be mclear_o=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-028 Reset released mid-measurement SHALL leave the block in IDLE; no mclear_o SHALL be issued.

Configuration
REQ-029 With macro TOF_CAPTURE_IRQ_EN defined, irq_o SHALL equal done_flag AND CONTROL.irq_en, registered.
REQ-030 Without TOF_CAPTURE_IRQ_EN, irq_o SHALL be constant 0, CONTROL bit1 SHALL read 0, and writes to that bit SHALL be ignored.

Verification
REQ-031 Scenario 1: enable=1, BLANK=10, WINDOW=500, start_i pulse, cmp_i[2] rises after the 137th ce_pcm_i -> exactly one mclear_o pulse, TOF[2]=137, other TOF=0xFFFF after WINDOW, STATUS[3]=1.
REQ-032 Scenario 2: all four cmp_i rise at ticks 40/41/42/43, BLANK=5 -> DONE entered the cycle after the last capture, STATUS[15:8]=0x0F, and TIMER stops advancing.
REQ-033 Scenario 3: cmp_i[0] held high from tick 0, BLANK=20 -> TOF[0]=20 (first LISTEN cycle), not 0.
REQ-034 Scenario 4: second start_i at tick 50 of LISTEN -> second mclear_o, timer restarts at 0, prior TOF values are overwritten with 0xFFFF.
REQ-035 Scenario 5: WINDOW=0xFFFF, ce_pcm_i held high for 70000 cycles -> timer saturates at 0xFFFF and DONE is reached.
REQ-036 Scenario 6: with TOF_CAPTURE_IRQ_EN, irq_en=1, the measurement completes -> irq_o=1; a STATUS write clears irq_o within 2 cycles; async reset mid-LISTEN gives IDLE with all outputs 0.
